// File: rtl/afe_emu_pkg.sv
// Shared types and constants for the PPG analog front-end emulator.
package afe_emu_pkg;

    typedef enum logic [1:0] {
        RISE = 2'd0,
        FALL = 2'd1,
        REST = 2'd2
    } beat_state_e;

    localparam logic [7:0] ADC_MIN          = 8'd0;
    localparam logic [7:0] ADC_MAX          = 8'd255;
    localparam int         DEF_RED_DC       = 100;
    localparam int         DEF_IR_DC        = 120;
    localparam int         DEF_COMP_STEP    = 10;
    localparam int         DEF_ADC_MID      = 128;

    // Saturate the offset-corrected amplifier output into the 8-bit ADC range.
    function automatic logic [7:0] clamp_adc(input logic signed [19:0] v);
        logic [7:0] r;
        if (v < 20'sd0) begin
            r = ADC_MIN;
        end else if (v > 20'sd255) begin
            r = ADC_MAX;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ppg_afe_emulator_if.sv
// Control/sample bus between the LED/PGA controller and the AFE emulator.
interface ppg_afe_emulator_if;
    logic       PULSE_EN;
    logic [3:0] LED_DRIVE;
    logic [6:0] DC_Comp;
    logic       LED_IR;
    logic       LED_RED;
    logic [3:0] PGA_Gain;
    logic [7:0] ADC;
    logic       Tick;

    modport master (
        output PULSE_EN, LED_DRIVE, DC_Comp, LED_IR, LED_RED, PGA_Gain,
        input  ADC, Tick
    );

    modport slave (
        input  PULSE_EN, LED_DRIVE, DC_Comp, LED_IR, LED_RED, PGA_Gain,
        output ADC, Tick
    );
endinterface

// File: rtl/ppg_beat_gen.sv
// Heartbeat envelope generator: tick divider, beat counter and RISE/FALL/REST shaper.
module ppg_beat_gen
    import afe_emu_pkg::*;
#(
    parameter int SAMPLE_DIV = 1,
    parameter int BEAT_LEN   = 1000,
    parameter int RISE_STEP  = 8,
    parameter int FALL_STEP  = 2,
    parameter int PEAK       = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_en,
    output logic [7:0] env,
    output logic       tick
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BEAT_W = (BEAT_LEN > 1) ? $clog2(BEAT_LEN) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_LEN - 1);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]        env_q, env_d;
    logic              tick_q, tick_d;
    beat_state_e       state_q, state_d;
    logic [8:0]        rise_sum_s;

    // Next-state for the divider, beat counter and envelope shaper.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        tick_d     = 1'b0;
        beat_cnt_d = beat_cnt_q;
        env_d      = env_q;
        state_d    = state_q;
        rise_sum_s = {1'b0, env_q} + 9'(RISE_STEP);

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (!pulse_en) begin
            env_d      = 8'd0;
            state_d    = RISE;
            beat_cnt_d = '0;
        end else if (tick_d) begin
            // Beat wrap outranks the shape transitions and leaves env untouched.
            if (beat_cnt_q == BEAT_LAST) begin
                beat_cnt_d = '0;
                state_d    = RISE;
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                case (state_q)
                    RISE: begin
                        if (rise_sum_s >= 9'(PEAK)) begin
                            env_d   = 8'(PEAK);
                            state_d = FALL;
                        end else begin
                            env_d   = rise_sum_s[7:0];
                        end
                    end
                    FALL: begin
                        if (env_q <= 8'(FALL_STEP)) begin
                            env_d   = 8'd0;
                            state_d = REST;
                        end else begin
                            env_d   = env_q - 8'(FALL_STEP);
                        end
                    end
                    REST: begin
                        env_d = 8'd0;
                    end
                    default: begin
                        env_d   = 8'd0;
                        state_d = RISE;
                    end
                endcase
            end
        end else begin
            env_d = env_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            beat_cnt_q <= '0;
            env_q      <= 8'd0;
            tick_q     <= 1'b0;
            state_q    <= RISE;
        end else begin
            div_cnt_q  <= div_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            env_q      <= env_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
        end
    end

    assign env  = env_q;
    assign tick = tick_q;

endmodule

// File: rtl/ppg_afe_emulator.sv
// PPG analog front-end emulator: channel select, photocurrent, DC subtraction,
// PGA gain and ADC clipping in a 3-stage pipeline fed by the beat generator.
module ppg_afe_emulator
    import afe_emu_pkg::*;
#(
    parameter int SAMPLE_DIV   = 1,
    parameter int BEAT_LEN     = 1000,
    parameter int RISE_STEP    = 8,
    parameter int FALL_STEP    = 2,
    parameter int PEAK         = 200,
    parameter int RED_DC       = DEF_RED_DC,
    parameter int IR_DC        = DEF_IR_DC,
    parameter int RED_AC_SHIFT = 5,
    parameter int IR_AC_SHIFT  = 5,
    parameter int COMP_STEP    = DEF_COMP_STEP,
    parameter int ADC_MID      = DEF_ADC_MID
) (
    input  logic                CLK,
    input  logic                rst,
    ppg_afe_emulator_if.slave   afe
);

    logic [7:0]         env_s;
    logic               tick_s;
    logic [8:0]         level_s;
    logic [12:0]        photo_q, photo_d;
    logic [10:0]        comp_q, comp_d;
    logic [3:0]         gain_q, gain_d;
    logic signed [13:0] diff_s;
    logic signed [18:0] diff_x_s, gain_x_s;
    logic [4:0]         gain_p1_s;
    logic signed [18:0] amp_q, amp_d;
    logic signed [19:0] sum_s;
    logic [7:0]         adc_q, adc_d;

    ppg_beat_gen #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .BEAT_LEN   (BEAT_LEN),
        .RISE_STEP  (RISE_STEP),
        .FALL_STEP  (FALL_STEP),
        .PEAK       (PEAK)
    ) u_beat (
        .clk      (CLK),
        .rst      (rst),
        .pulse_en (afe.PULSE_EN),
        .env      (env_s),
        .tick     (tick_s)
    );

    // Channel select and the three pipeline stage computations.
    always_comb begin
        case ({afe.LED_RED, afe.LED_IR})
            2'b10:   level_s = 9'(RED_DC) + 9'(env_s >> RED_AC_SHIFT);
            2'b01:   level_s = 9'(IR_DC) + 9'(env_s >> IR_AC_SHIFT);
            default: level_s = 9'd0;
        endcase

        photo_d = 13'(afe.LED_DRIVE) * 13'(level_s);
        comp_d  = 11'(afe.DC_Comp) * 11'(COMP_STEP);
        gain_d  = afe.PGA_Gain;

        // Differential input can be negative when compensation exceeds photocurrent.
        diff_s    = $signed({1'b0, photo_q}) - $signed({3'b000, comp_q});
        gain_p1_s = {1'b0, gain_q} + 5'd1;
        diff_x_s  = 19'(diff_s);
        gain_x_s  = {14'd0, gain_p1_s};
        amp_d     = diff_x_s * gain_x_s;

        sum_s = 20'(amp_q) + 20'(ADC_MID);
        adc_d = clamp_adc(sum_s);
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            photo_q <= 13'd0;
            comp_q  <= 11'd0;
            gain_q  <= 4'd0;
            amp_q   <= 19'sd0;
            adc_q   <= 8'd0;
        end else begin
            photo_q <= photo_d;
            comp_q  <= comp_d;
            gain_q  <= gain_d;
            amp_q   <= amp_d;
            adc_q   <= adc_d;
        end
    end

    assign afe.ADC  = adc_q;
    assign afe.Tick = tick_s;

endmodule

// File: tb/tb_ppg_afe_emulator.sv
// Directed bench for ppg_afe_emulator with a 3-deep ADC scoreboard and an envelope model.
module tb_ppg_afe_emulator;

    logic CLK;
    logic rst;
    ppg_afe_emulator_if afe_if();

    ppg_afe_emulator dut (
        .CLK (CLK),
        .rst (rst),
        .afe (afe_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    int         m_env  = 0;
    int         m_st   = 0;
    int         m_beat = 0;
    int         adc_max = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_adc();
        int lvl;
        int v;
        if (afe_if.LED_RED && !afe_if.LED_IR)      lvl = 100 + (m_env >> 5);
        else if (afe_if.LED_IR && !afe_if.LED_RED) lvl = 120 + (m_env >> 5);
        else                                       lvl = 0;
        v = (int'(afe_if.LED_DRIVE) * lvl - int'(afe_if.DC_Comp) * 10)
            * (int'(afe_if.PGA_Gain) + 1) + 128;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic model_edge();
        if (!afe_if.PULSE_EN) begin
            m_env = 0; m_st = 0; m_beat = 0;
        end else if (m_beat == 999) begin
            m_beat = 0; m_st = 0;
        end else begin
            m_beat++;
            if (m_st == 0) begin
                if (m_env + 8 >= 200) begin m_env = 200; m_st = 1; end
                else m_env = m_env + 8;
            end else if (m_st == 1) begin
                if (m_env <= 2) begin m_env = 0; m_st = 2; end
                else m_env = m_env - 2;
            end else begin
                m_env = 0;
            end
        end
    endtask

    task automatic step();
        logic [7:0] e;
        if (!rst) begin
            e = model_adc();
            sb_q.push_back(e);
        end
        @(posedge CLK);
        if (rst) begin
            m_env = 0; m_st = 0; m_beat = 0;
            sb_q.delete();
        end else begin
            model_edge();
        end
        #1;
        if (!rst) begin
            chk("tick_every_cycle", 32'(afe_if.Tick), 32'd1);
            if (sb_q.size() >= 3) begin
                e = sb_q.pop_front();
                chk("sb_adc", 32'(afe_if.ADC), 32'(e));
            end
            if (int'(afe_if.ADC) > adc_max) adc_max = int'(afe_if.ADC);
        end
    endtask

    initial begin
        // Reset with arbitrary inputs.
        rst = 1'b1;
        afe_if.PULSE_EN = 1'b1; afe_if.LED_DRIVE = 4'd7; afe_if.DC_Comp = 7'd33;
        afe_if.LED_RED = 1'b1; afe_if.LED_IR = 1'b0; afe_if.PGA_Gain = 4'd3;
        repeat (2) step();
        chk("rst_adc", 32'(afe_if.ADC), 32'd0);
        chk("rst_tick", 32'(afe_if.Tick), 32'd0);
        chk("rst_env", 32'(dut.u_beat.env_q), 32'd0);
        chk("rst_beat", 32'(dut.u_beat.beat_cnt_q), 32'd0);

        rst = 1'b0;
        afe_if.PULSE_EN = 1'b0; afe_if.DC_Comp = 7'd0;
        afe_if.LED_RED = 1'b0; afe_if.LED_IR = 1'b0; afe_if.PGA_Gain = 4'd0;
        repeat (4) step();
        chk("idle_mid", 32'(afe_if.ADC), 32'd128);

        // Red channel, static envelope, DC compensation sweep.
        afe_if.LED_RED = 1'b1; afe_if.LED_DRIVE = 4'd10;
        afe_if.DC_Comp = 7'd100; repeat (4) step(); chk("red_comp100", 32'(afe_if.ADC), 32'd128);
        afe_if.DC_Comp = 7'd127; repeat (4) step(); chk("red_clip_lo", 32'(afe_if.ADC), 32'd0);
        afe_if.DC_Comp = 7'd90;  repeat (4) step(); chk("red_comp90", 32'(afe_if.ADC), 32'd228);
        afe_if.PGA_Gain = 4'd1;  repeat (4) step(); chk("red_clip_hi", 32'(afe_if.ADC), 32'd255);

        // IR channel.
        afe_if.PGA_Gain = 4'd0; afe_if.LED_RED = 1'b0; afe_if.LED_IR = 1'b1;
        afe_if.DC_Comp = 7'd30;  repeat (4) step(); chk("ir_comp30", 32'(afe_if.ADC), 32'd255);
        afe_if.DC_Comp = 7'd120; repeat (4) step(); chk("ir_comp120", 32'(afe_if.ADC), 32'd128);

        // Toggle channels every 10 cycles; ADC must switch exactly 3 cycles later.
        afe_if.DC_Comp = 7'd110; repeat (4) step();
        for (int i = 0; i < 6; i++) begin
            afe_if.LED_RED = (i % 2 == 0);
            afe_if.LED_IR  = (i % 2 != 0);
            step(); step();
            chk("lag_hold", 32'(afe_if.ADC), (i % 2 == 0) ? 32'd228 : 32'd28);
            step();
            chk("lag_new", 32'(afe_if.ADC), (i % 2 == 0) ? 32'd28 : 32'd228);
            repeat (7) step();
        end

        // Both LEDs on is dark.
        afe_if.LED_RED = 1'b1; afe_if.LED_IR = 1'b1; afe_if.LED_DRIVE = 4'd15;
        afe_if.DC_Comp = 7'd0;  repeat (4) step(); chk("dark_mid", 32'(afe_if.ADC), 32'd128);
        afe_if.DC_Comp = 7'd13; repeat (4) step(); chk("dark_clip", 32'(afe_if.ADC), 32'd0);

        // Heartbeat on the red channel.
        afe_if.LED_IR = 1'b0; afe_if.LED_DRIVE = 4'd10; afe_if.DC_Comp = 7'd100;
        repeat (4) step();
        adc_max = 0;
        afe_if.PULSE_EN = 1'b1;
        repeat (25) step();
        chk("env_peak", 32'(dut.u_beat.env_q), 32'd200);
        chk("state_fall", 32'(dut.u_beat.state_q), 32'd1);
        repeat (100) step();
        chk("env_zero", 32'(dut.u_beat.env_q), 32'd0);
        chk("state_rest", 32'(dut.u_beat.state_q), 32'd2);
        chk("adc_peak", 32'(adc_max), 32'd188);
        repeat (874) step();
        chk("beat_last", 32'(dut.u_beat.beat_cnt_q), 32'd999);
        chk("adc_rest", 32'(afe_if.ADC), 32'd128);
        step();
        chk("wrap_beat", 32'(dut.u_beat.beat_cnt_q), 32'd0);
        chk("wrap_state", 32'(dut.u_beat.state_q), 32'd0);
        chk("wrap_env", 32'(dut.u_beat.env_q), 32'd0);
        step();
        chk("wrap_rise", 32'(dut.u_beat.env_q), 32'd8);
        repeat (49) step();
        chk("mid_fall_beat", 32'(dut.u_beat.beat_cnt_q), 32'd50);
        chk("mid_fall_env", 32'(dut.u_beat.env_q), 32'd150);

        // One-cycle reset in the middle of FALL.
        rst = 1'b1;
        step();
        chk("mrst_adc", 32'(afe_if.ADC), 32'd0);
        chk("mrst_tick", 32'(afe_if.Tick), 32'd0);
        chk("mrst_env", 32'(dut.u_beat.env_q), 32'd0);
        chk("mrst_beat", 32'(dut.u_beat.beat_cnt_q), 32'd0);
        chk("mrst_state", 32'(dut.u_beat.state_q), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_env", 32'(dut.u_beat.env_q), 32'd8);
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
